// File: rtl/prirv32_defines_pkg.sv
// Shared RV32 fetch-path constants and the {pc, instr} fetch entry layout.
package prirv32_defines;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ILEN          = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prirv32_sync_fifo.sv
// Synchronous FIFO with flush; head entry is always visible on data_o (stale when empty).
module prirv32_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage is reset so the stale head reads as zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/prirv32_prefetch_buf.sv
// Instruction prefetch buffer: credit-based sequential ITCM fetch into a FIFO, flushed on redirect.
// Optional combinational empty-FIFO bypass under `PRIRV32_PREFETCH_BYPASS_EN.
module prirv32_prefetch_buf
    import prirv32_defines::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            itcm_req_o,
    output logic [XLEN-1:0] itcm_addr_o,
    input  logic [ILEN-1:0] itcm_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            empty_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            fifo_push, fifo_pop;
    logic [FETCH_ENTRY_W-1:0] fifo_rdata;
    fetch_entry_t    head, resp_entry, out_entry;

    logic            resp_valid, pop, credit_ok, issue;
    logic [OW-1:0]   occupancy;
    logic            redir_lsb_unused;

    assign redir_lsb_unused = ^redirect_pc_i[1:0];

    assign head       = fetch_entry_t'(fifo_rdata);
    assign resp_entry = {inflight_pc_q, itcm_data_i};
    assign resp_valid = inflight_q & ~redirect_i;
    assign pop        = instr_valid_o & instr_ready_i & ~redirect_i;

`ifdef PRIRV32_PREFETCH_BYPASS_EN
    logic bypass;
    // An arriving response may be handed straight to the IFU when nothing is queued ahead of it.
    assign bypass        = fifo_empty & resp_valid;
    assign instr_valid_o = ~fifo_empty | bypass;
    assign out_entry     = bypass ? resp_entry : head;
    assign fifo_push     = resp_valid & ~(bypass & instr_ready_i);
    assign fifo_pop      = pop & ~bypass;
`else
    assign instr_valid_o = ~fifo_empty;
    assign out_entry     = head;
    assign fifo_push     = resp_valid;
    assign fifo_pop      = pop;
`endif

    assign instr_o    = out_entry.instr;
    assign instr_pc_o = out_entry.pc;
    assign empty_o    = fifo_empty;

    // Slots are reserved for the in-flight response, so a push never meets a full FIFO.
    assign occupancy = OW'(fifo_count) + OW'(inflight_q);
    assign credit_ok = (occupancy - OW'(pop)) < OW'(DEPTH);
    assign issue     = ~rst_i & (redirect_i | credit_ok);

    assign itcm_req_o  = issue;
    assign itcm_addr_o = redirect_i ? {redirect_pc_i[XLEN-1:2], 2'b00} : fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            fetch_pc_d    = itcm_addr_o + 32'd4;
            inflight_pc_d = itcm_addr_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    prirv32_sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (fifo_push),
        .data_i  (resp_entry),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_full && fifo_push && !fifo_pop));

endmodule

// File: tb/tb_prirv32_prefetch_buf.sv
// Scoreboard bench for prirv32_prefetch_buf; ITCM model returns word index (addr>>2) as data.
module tb_prirv32_prefetch_buf;

    localparam int unsigned DEPTH = 4;
`ifdef PRIRV32_PREFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        itcm_req_o;
    logic [31:0] itcm_addr_o;
    logic [31:0] itcm_data_i = '0;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        empty_o;

    int n_checks = 0;
    int n_fail   = 0;
    int delivered = 0;
    logic [31:0] exp_q[$];

    prirv32_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .itcm_req_o    (itcm_req_o),
        .itcm_addr_o   (itcm_addr_o),
        .itcm_data_i   (itcm_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (itcm_req_o === 1'b1) itcm_data_i <= itcm_addr_o >> 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_i === 1'b0 && instr_valid_o && instr_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %h, expected none", instr_pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("deliv_pc", instr_pc_o, e);
                chk("deliv_instr", instr_o, e >> 2);
            end
            delivered++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_deliv(input int n);
        int target;
        target = delivered + n;
        for (int i = 0; i < 60 && delivered < target; i++) step();
        chk("wait_deliv", 32'(delivered >= target), 32'd1);
    endtask

    initial begin
        logic [31:0] h;
        rst_i = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        step(); step();
        #1;
        chk("rst_req", itcm_req_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_empty", empty_o, 1);

        // Sequential streaming from RESET_PC
        push_seq(32'h0, 64);
        step(); rst_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk("first_req", itcm_req_o, 1);
        chk("addr0", itcm_addr_o, 32'h0);
        chk("lat_n_valid", instr_valid_o, 0);
        step(); #1;
        chk("addr1", itcm_addr_o, 32'h4);
        chk("lat_n1_valid", instr_valid_o, BYP);
        step(); #1;
        chk("addr2", itcm_addr_o, 32'h8);
        chk("lat_n2_valid", instr_valid_o, 1);
        chk("lat_n2_pc", instr_pc_o, BYP ? 32'h4 : 32'h0);
        step(); step(); step();

        // Stall: exactly DEPTH entries buffered, fetch stops
        instr_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #1;
        h = exp_q[0];
        chk("stall_req", itcm_req_o, 0);
        chk("stall_valid", instr_valid_o, 1);
        chk("stall_head_pc", instr_pc_o, h);
        chk("stall_fetch_pc", itcm_addr_o, h + 32'(4 * DEPTH));

        // One pop frees a credit and fetch resumes the same cycle
        step(); instr_ready_i = 1'b1; #1;
        chk("resume_req", itcm_req_o, 1);
        chk("resume_addr", itcm_addr_o, h + 32'(4 * DEPTH));

        // Redirect while full with a response in flight
        step(); instr_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        push_seq(32'h100, 40); #1;
        chk("redir_req", itcm_req_o, 1);
        chk("redir_addr", itcm_addr_o, 32'h100);
        step(); redirect_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk("redir_r1_valid", instr_valid_o, BYP);
        step(); #1;
        chk("redir_r2_valid", instr_valid_o, 1);
        chk("redir_r2_pc", instr_pc_o, BYP ? 32'h104 : 32'h100);
        wait_deliv(3);

        // Redirect coinciding with a valid handshake voids the pop
        step(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        push_seq(32'h200, 40); #1;
        chk("redir_hs_valid", instr_valid_o, 1);
        chk("redir_hs_addr", itcm_addr_o, 32'h200);
        step(); redirect_i = 1'b0;
        wait_deliv(4);

        // Address wrap at the top of memory
        step(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8, 40); #1;
        chk("wrap_addr", itcm_addr_o, 32'hFFFF_FFF8);
        step(); redirect_i = 1'b0;
        wait_deliv(4);

        // Asynchronous reset mid-stream with entries buffered
        step(); instr_ready_i = 1'b0;
        step(); step(); #1;
        chk("pre_rst_nonempty", empty_o, 0);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_req", itcm_req_o, 0);
        chk("arst_valid", instr_valid_o, 0);
        chk("arst_instr", instr_o, 0);
        chk("arst_pc", instr_pc_o, 0);
        chk("arst_empty", empty_o, 1);
        push_seq(32'h0, 40);
        step(); rst_i = 1'b0; instr_ready_i = 1'b1; #1;
        chk("rerst_req", itcm_req_o, 1);
        chk("rerst_addr", itcm_addr_o, 32'h0);
        step(); #1;
        chk("rerst_n1_valid", instr_valid_o, BYP);
        step(); #1;
        chk("rerst_n2_valid", instr_valid_o, 1);
        chk("rerst_n2_pc", instr_pc_o, BYP ? 32'h4 : 32'h0);
        wait_deliv(3);

        instr_ready_i = 1'b0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prirv32_prefetch_buf.md
Name: prirv32_prefetch_buf

Overview:
- Instruction prefetch buffer between the ITCM port and the IFU.
- Issues sequential word fetches to a synchronous ITCM and holds returned {pc, instr} pairs in a small FIFO.
- Presents them to the IFU over a valid/ready handshake.
- Flushes and refetches on a branch/jump redirect from the execute path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-high
- itcm_req_o  out  1  fetch request this cycle
- itcm_addr_o  out  32  fetch address, word-aligned
- itcm_data_i  in  32  read data; valid exactly one cycle after an accepted request
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced 0)
- instr_valid_o  out  1  head entry valid
- instr_ready_i  in  1  IFU accepts head
- instr_o  out  32  head instruction
- instr_pc_o  out  32  head instruction address
- empty_o  out  1  FIFO empty (debug/perf)

Behaviour:
- Reset (async, rst_i high):
  - fetch_pc=RESET_PC; FIFO pointers and count=0; inflight=0.
  - Outputs: itcm_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, empty_o=1.
- State:
  - fetch_pc: next sequential address.
  - inflight: 1 bit, request issued last cycle.
  - inflight_pc.
  - FIFO: DEPTH x 64 bits, rd_ptr/wr_ptr, count 0..DEPTH.
- Credit rule: pop = instr_valid_o & instr_ready_i & ~redirect_i. Issue when (count + inflight - pop) < DEPTH. An in-flight response therefore always has a slot, so no overflow is possible.
- ITCM is always ready: itcm_req_o=1 means the request is accepted. Only one request is ever outstanding per cycle (pipelined, one per cycle).
- Address:
  - itcm_addr_o = redirect_i ? {redirect_pc_i[31:2],2'b00} : fetch_pc.
  - On issue, fetch_pc <= itcm_addr_o + 4. Wraps 32'hFFFFFFFC -> 0 silently.
- Response: when inflight=1, push {inflight_pc, itcm_data_i} at the cycle end, unless redirect_i is high that cycle (response dropped).
- Redirect, same cycle:
  - Count and pointers clear.
  - Any pending response is discarded.
  - Pop is suppressed; the IFU handshake is void.
  - A request to the redirect address issues in that same cycle (FIFO now empty).
  - Redirect with rst_i: reset wins.
- Latency, no bypass: request in cycle N -> data in cycle N+1 -> instr_valid_o in cycle N+2. Redirect-to-first-valid is 2 cycles.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: itcm_req_o=0 while the credit rule fails. Resumes the same cycle a pop frees a credit.
- Empty: instr_valid_o=0. instr_o and instr_pc_o show the stale head entry (don't-care for the IFU).
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: PRIRV32_PREFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a response arrives (not redirected), it drives instr_valid_o/instr_o/instr_pc_o combinationally in cycle N+1.
  - If accepted that cycle, it is not pushed. Otherwise it is pushed normally.
  - Redirect-to-first-valid becomes 1 cycle.
  - The credit rule is unchanged.
- Undefined: all outputs are registered from the FIFO, with latency as above.

Decomposition:
- Shared package/include prirv32_defines:
  - XLEN=32, ILEN=32, RESET_PC default.
  - Fetch entry layout: {pc[31:0], instr[31:0]}, width constant FETCH_ENTRY_W=64.
- One sub-module: prirv32_sync_fifo (parameterised WIDTH/DEPTH, push/pop/flush, count, full/empty). The prefetch buffer owns credit, issue and redirect logic around it.

Test Plan:
- Reset release, instr_ready_i=1, ITCM word[i]=i:
  - itcm_addr_o sequence 0,4,8,...
  - First instr_valid_o two cycles after the first request, instr_pc_o=0, instr_o=0.
  - Then one instruction per cycle with consecutive PCs.
- instr_ready_i=0 for 10 cycles: exactly DEPTH=4 entries are buffered (PCs 0..C), with no extra request once count+inflight=4. Ready high: PCs 0,4,8,C,10 emerge in order with no loss or duplicate.
- Redirect to 32'h00000103 while full and a response is in flight:
  - Same-cycle itcm_addr_o=32'h100.
  - The stale response is not delivered.
  - Next valid has instr_pc_o=32'h100, then 32'h104.
- Redirect in the same cycle as instr_valid_o & instr_ready_i: the head is not consumed (count unaffected). Output restarts at the redirect PC.
- Redirect to 32'hFFFFFFF8: PCs FFFFFFF8, FFFFFFFC, 00000000 in order.
- rst_i asserted mid-stream with FIFO half full: outputs drop to reset values asynchronously. After release, fetch restarts at RESET_PC. With PRIRV32_PREFETCH_BYPASS_EN, the first valid appears one cycle after the request.
